// File: rtl/q2_16b_serial_sub_if.sv
// Start/done handshake and operand/result bundle for the nibble-serial subtractor.
interface q2_16b_serial_sub_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        Bin;
  logic [15:0] diff;
  logic        Bout;
  logic        overflow;
  logic        zero;
  logic        busy;
  logic        done;

  modport master (output start, a, b, Bin,
                  input  diff, Bout, overflow, zero, busy, done);
  modport slave  (input  start, a, b, Bin,
                  output diff, Bout, overflow, zero, busy, done);
endinterface

// File: rtl/q2_16b_serial_sub.sv
// Nibble-serial 16-bit subtractor: a - b - Bin, one 4-bit slice per clock with a
// registered borrow; results only update on entry to DONE.
module q2_16b_serial_sub (
  input  logic            clk,
  input  logic            rst,
  q2_16b_serial_sub_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] a_q, b_q, acc, acc_mrg;
  logic [1:0]  cnt;
  logic        br, br_nxt;
  logic [3:0]  d;
  logic [15:0] diff_q;
  logic        bout_q, ovf_q, zero_q, busy_q, done_q;

  // Single shared 4-bit slice; the counter picks which nibble it works on.
  always_comb begin
    logic [4:0] s;
    s = {1'b0, a_q[cnt*4 +: 4]} - {1'b0, b_q[cnt*4 +: 4]} - {4'b0, br};
    d       = s[3:0];
    br_nxt  = s[4];
    acc_mrg = acc;
    acc_mrg[cnt*4 +: 4] = d;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a_q <= bus.a;
          b_q <= bus.b;
          br  <= bus.Bin;
          cnt <= '0;
        end
        RUN: begin
          acc <= acc_mrg;
          br  <= br_nxt;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            diff_q <= acc_mrg;
            bout_q <= br_nxt;
            ovf_q  <= (a_q[15] != b_q[15]) && (acc_mrg[15] != a_q[15]);
            zero_q <= (acc_mrg == 16'h0000);
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff     = diff_q;
  assign bus.Bout     = bout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_q2_16b_serial_sub.sv
// Directed vector bench for q2_16b_serial_sub: table of hand-computed results
// plus sequences for busy rejection, mid-run reset and back-to-back throughput.
module tb_q2_16b_serial_sub;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  q2_16b_serial_sub_if bus();
  q2_16b_serial_sub dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one op from IDLE, checks busy, 4-edge latency and one-cycle done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output logic ok);
    int k;
    ok = 1'b0;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.Bin = bin; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_accept", {15'b0, bus.busy}, 16'd1);
    k = 1;
    while (k <= 10) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) break;
      k++;
    end
    chk("done_latency", 16'(k), 16'd4);
    ok = (k == 4);
  endtask

  task automatic chk_done_falls();
    @(negedge clk);
    chk("done_one_cycle", {15'b0, bus.done}, 16'd0);
    chk("busy_idle", {15'b0, bus.busy}, 16'd0);
  endtask

  initial begin
    logic ok;
    int   done_cnt;
    int   cyc;
    int   dcyc [$];

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.Bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_diff", bus.diff, 16'h0);
    chk("rst_flags", {10'b0, bus.Bout, bus.overflow, bus.zero, bus.busy, bus.done, 1'b0}, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, ok);
      chk($sformatf("v%0d_diff", i), bus.diff, vecs[i].diff);
      chk($sformatf("v%0d_bout", i), {15'b0, bus.Bout}, {15'b0, vecs[i].bout});
      chk($sformatf("v%0d_ovf", i), {15'b0, bus.overflow}, {15'b0, vecs[i].ovf});
      chk($sformatf("v%0d_zero", i), {15'b0, bus.zero}, {15'b0, vecs[i].zero});
      chk_done_falls();
      chk($sformatf("v%0d_hold", i), bus.diff, vecs[i].diff);
    end

    // Busy rejection and operand stability.
    done_cnt = 0;
    @(negedge clk);
    bus.a = 16'h00F0; bus.b = 16'h000F; bus.Bin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'hFFFF;
    @(negedge clk);
    chk("run_hold_prev", bus.diff, 16'h0002);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        chk("busy_rej_diff", bus.diff, 16'h00E1);
      end
    end
    chk("busy_rej_single_done", 16'(done_cnt), 16'd1);
    chk("busy_rej_idle", {15'b0, bus.busy}, 16'd0);

    // Reset at E2 of a new operation.
    @(negedge clk);
    bus.a = 16'h1111; bus.b = 16'h0000; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_diff", bus.diff, 16'h0);
    chk("midrst_flags", {11'b0, bus.Bout, bus.overflow, bus.zero, bus.busy, bus.done}, 16'h0);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("midrst_no_done", 16'(done_cnt), 16'd0);
    run_op(16'h0003, 16'h0001, 1'b0, ok);
    chk("post_rst_diff", bus.diff, 16'h0002);
    chk_done_falls();

    // Back-to-back with start held: A000 - 2000 = 8000 (-24576 - 8192 = -32768, no overflow).
    @(negedge clk);
    bus.a = 16'hA000; bus.b = 16'h2000; bus.Bin = 1'b0; bus.start = 1'b1;
    cyc = 0;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.done) begin
        dcyc.push_back(cyc);
        chk("b2b_diff", bus.diff, 16'h8000);
        chk("b2b_flags", {14'b0, bus.overflow, bus.Bout}, 16'b0);
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", 16'(dcyc.size()), 16'd3);
    if (dcyc.size() == 3) begin
      chk("b2b_first", 16'(dcyc[0]), 16'd5);
      chk("b2b_gap1", 16'(dcyc[1] - dcyc[0]), 16'd6);
      chk("b2b_gap2", 16'(dcyc[2] - dcyc[1]), 16'd6);
    end
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
